dot_product_seq: RTL and testbench
==================================

# dot_product_seq

Sequential, parametrised scalar-product engine for the matmul datapath. Accepts two packed vectors of NDATA elements of NBITS each and multiplies NLANES element pairs per cycle through the existing combinational `multiply` lane array. It accumulates the lane sums into a full-precision dot product and also returns every individual product in element order. Signed or unsigned operation is selected per transaction. Valid/ready handshakes on input and output let it sit between the operand fetch and the result writeback stages.

## Interface
- NBITS, 4, element width in bits
- NDATA, 8, elements per vector; must be a multiple of NLANES
- NLANES, 4, multiplier lanes used per cycle
- Derived: PASSES = NDATA/NLANES; ACC_W = 2*NBITS + clog2(NDATA)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  operand vectors valid
- in_ready  out  1  block can accept operands
- is_signed  in  1  1 = two's-complement elements, 0 = unsigned; sampled on accept
- a  in  NDATA*NBITS  vector A; element i at bits [i*NBITS +: NBITS]
- b  in  NDATA*NBITS  vector B; same packing as A
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  ACC_W  sum of a[i]*b[i]
- out_prod  out  NDATA*2*NBITS  product i at bits [i*2*NBITS +: 2*NBITS]
- busy  out  1  high in RUN or DONE

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1 (forced 0 while reset is high).
  - Accept happens when in_valid && in_ready. On accept: latch a, b and is_signed into shift registers; clear the accumulator, out_prod and the pass counter; go to RUN.
- RUN, each cycle:
  - Feed the low NLANES elements of the A and B shift registers to `multiply`.
  - Add the extended sum of the NLANES products to the accumulator.
  - Shift the NLANES products into out_prod from the MSB end. After the last pass, element 0 sits at the LSB.
  - Shift A and B right by NLANES*NBITS.
  - Increment the pass counter. After pass PASSES-1, go to DONE.
- DONE:
  - out_valid = 1.
  - result and out_prod are stable until out_valid && out_ready, then the FSM returns to IDLE.
- in_valid is ignored outside IDLE. Inputs a, b and is_signed may change freely after the accept edge.
- Arithmetic:
  - Unsigned mode: operands are zero-extended.
  - Signed mode: operands are treated as two's complement. Each product is the exact 2*NBITS two's-complement value and is sign-extended to ACC_W before accumulation.
  - ACC_W is wide enough that overflow cannot occur in either mode.
- In IDLE, result and out_prod hold the last transaction's values until the next accept.
- Reset mid-operation: the FSM returns to IDLE at the next edge, the in-flight transaction is discarded, and all registers are cleared.

## Timing
- Reset values: in_ready 0 while reset is high, then 1; out_valid 0; result 0; out_prod 0; busy 0.
- Latency: out_valid rises on the PASSES-th rising edge after the accept edge.
  - Example: NDATA=8, NLANES=4 gives out_valid 2 edges after accept.
- Minimum initiation interval is PASSES+2 cycles: PASSES in RUN, at least 1 in DONE, 1 in IDLE.
  - No accept is possible in the same cycle as an out_ready handshake.
- in_ready and out_valid are functions of registered state only; there is no combinational path from in_valid or out_ready.
- out_valid with out_ready held low: DONE is held indefinitely and outputs do not change.

## Structure
- Package `dot_pkg`:
  - state typedef (IDLE, RUN, DONE)
  - functions computing ACC_W and PASSES from the parameters
- Sub-module: the existing combinational `multiply`, instantiated once with Ndata=NLANES.
  - Each lane needs signed/unsigned selection. Extend `multiply` with an `is_signed` input defaulting to unsigned, so existing users are unaffected.
- Lane-sum adder tree and accumulator live in dot_product_seq.

## Test plan
- Unsigned, defaults:
  - Stimulus: a elements 0..7 (elem i = i), b elem i = 7-i.
  - Required response: out_valid 2 edges after accept; result = 56; out_prod elements = 0,6,10,12,12,10,6,0.
- Signed: all a = 4'hF (-1), all b = 4'd7, is_signed=1 -> result = -56 = 11'h7C8; each product = 8'hF9.
- Unsigned max: all a = b = 4'hF -> result = 1800 (11'h708); each product = 8'hE1.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE, with in_valid pulsed during RUN and DONE.
  - Required response: out_valid, result and out_prod stable; in_ready = 0; no second transaction starts. After the handshake, in_ready = 1 on the next cycle.
- Reset mid-RUN: assert reset after the first pass -> out_valid never rises, all outputs are 0. A following transaction (test 1 vectors) gives result = 56.
- Parameter sweep:
  - NLANES=8 (PASSES=1) and NLANES=1 (PASSES=8) with test 1 vectors -> result = 56, with latency of 1 and 8 edges respectively.
  - Random signed/unsigned vectors checked against a behavioural model.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and sizing helpers for the sequential dot-product engine.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision accumulator width: one product plus growth for NDATA terms.
    function automatic int acc_width(input int nbits, input int ndata);
        return 2 * nbits + $clog2(ndata);
    endfunction

    function automatic int pass_count(input int ndata, input int nlanes);
        return ndata / nlanes;
    endfunction

endpackage

// File: rtl/multiply.sv
// Combinational lane array: Ndata independent NBITS x NBITS multipliers.
module multiply #(
    parameter int NBITS = 4,
    parameter int Ndata = 4
) (
    input  logic [Ndata*NBITS-1:0]   a,
    input  logic [Ndata*NBITS-1:0]   b,
    input  logic                     is_signed = 1'b0,
    output logic [Ndata*2*NBITS-1:0] prod
);

    // Operands are widened to the product width, so the truncated product is exact in both modes.
    for (genvar i = 0; i < Ndata; i++) begin : g_lane
        logic [2*NBITS-1:0] w_ax;
        logic [2*NBITS-1:0] w_bx;
        assign w_ax = {{NBITS{is_signed & a[i*NBITS+NBITS-1]}}, a[i*NBITS +: NBITS]};
        assign w_bx = {{NBITS{is_signed & b[i*NBITS+NBITS-1]}}, b[i*NBITS +: NBITS]};
        assign prod[i*2*NBITS +: 2*NBITS] = w_ax * w_bx;
    end

endmodule

// File: rtl/dot_product_seq.sv
// Sequential dot-product engine: NLANES element pairs per cycle, full-precision
// accumulation, and every individual product returned in element order.
module dot_product_seq
    import dot_pkg::*;
#(
    parameter int NBITS  = 4,
    parameter int NDATA  = 8,
    parameter int NLANES = 4,
    localparam int ACC_W  = acc_width(NBITS, NDATA),
    localparam int PASSES = pass_count(NDATA, NLANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    is_signed,
    input  logic [NDATA*NBITS-1:0]  a,
    input  logic [NDATA*NBITS-1:0]  b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        result,
    output logic [NDATA*2*NBITS-1:0] out_prod,
    output logic                    busy
);

    localparam int LANE_W = NLANES * NBITS;
    localparam int VEC_W  = NDATA * NBITS;
    localparam int P_W    = 2 * NBITS;
    localparam int LP_W   = NLANES * P_W;
    localparam int PROD_W = NDATA * P_W;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_t             r_state;
    logic [VEC_W-1:0]   r_a;
    logic [VEC_W-1:0]   r_b;
    logic               r_signed;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [PROD_W-1:0]  r_prod;

    logic [LP_W-1:0]    w_lane_prod;
    logic [ACC_W-1:0]   w_lane_sum;
    logic [P_W-1:0]     w_p;
    logic [PROD_W-1:0]  w_prod_next;

    multiply #(.NBITS(NBITS), .Ndata(NLANES)) u_multiply (
        .a         (r_a[LANE_W-1:0]),
        .b         (r_b[LANE_W-1:0]),
        .is_signed (r_signed),
        .prod      (w_lane_prod)
    );

    // Lane-sum adder tree; each product is extended to the accumulator width.
    always_comb begin
        w_lane_sum = '0;
        w_p        = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_p        = w_lane_prod[i*P_W +: P_W];
            w_lane_sum = w_lane_sum + {{(ACC_W-P_W){r_signed & w_p[P_W-1]}}, w_p};
        end
    end

    // New products enter at the MSB end so element 0 lands at the LSB after the last pass.
    if (PASSES == 1) begin : g_prod_single
        assign w_prod_next = w_lane_prod;
    end else begin : g_prod_shift
        assign w_prod_next = {w_lane_prod, r_prod[PROD_W-1:LP_W]};
    end

    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_acc;
    assign out_prod  = r_prod;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= is_signed;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_prod   <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc  <= r_acc + w_lane_sum;
                    r_prod <= w_prod_next;
                    r_a    <= r_a >> LANE_W;
                    r_b    <= r_b >> LANE_W;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(PASSES - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench: table-driven transactions with a scoreboard queue, plus
// backpressure, mid-run reset and lane-count variants.
module tb_dot_product_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [10:0] res;
        logic [63:0] prod;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        iv [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov [3];
    logic        bsy [3];
    logic [10:0] res [3];
    logic [63:0] prod [3];

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [$];
    vec_t sb [$];

    always #5 clk = ~clk;

    dot_product_seq #(.NBITS(4), .NDATA(8), .NLANES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .is_signed(sgn),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]),
        .out_prod(prod[0]), .busy(bsy[0]));

    dot_product_seq #(.NBITS(4), .NDATA(8), .NLANES(8)) dut_l8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .is_signed(sgn),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]),
        .out_prod(prod[1]), .busy(bsy[1]));

    dot_product_seq #(.NBITS(4), .NDATA(8), .NLANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .is_signed(sgn),
        .a(a), .b(b), .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]),
        .out_prod(prod[2]), .busy(bsy[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [31:0] va, input logic [31:0] vb, input logic s);
        vec_t        v;
        int          sum;
        int          x;
        int          y;
        logic [31:0] pr;
        v.a = va; v.b = vb; v.sgn = s; v.prod = '0;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            x = int'(va[i*4 +: 4]);
            y = int'(vb[i*4 +: 4]);
            if (s && x > 7) x = x - 16;
            if (s && y > 7) y = y - 16;
            pr = 32'(x * y);
            v.prod[i*8 +: 8] = pr[7:0];
            sum = sum + x * y;
        end
        pr    = 32'(sum);
        v.res = pr[10:0];
        return v;
    endfunction

    // One full transaction on instance d, checking latency and results via the scoreboard.
    task automatic run_txn(input int d, input vec_t v, input int lat);
        vec_t e;
        int   edges;
        @(negedge clk);
        a = v.a; b = v.b; sgn = v.sgn; iv[d] = 1'b1;
        chk("in_ready_idle", 64'(irdy[d]), 64'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        sb.push_back(v);
        a = $urandom; b = $urandom; sgn = ~sgn;
        chk("busy_run", 64'(bsy[d]), 64'd1);
        edges = 0;
        while (!ov[d] && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(lat));
        if (ov[d] && sb.size() > 0) begin
            e = sb.pop_front();
            chk("result", 64'(res[d]), 64'(e.res));
            chk("out_prod", prod[d], e.prod);
        end else begin
            chk("out_valid_seen", 64'(ov[d]), 64'd1);
        end
        @(negedge clk);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk("out_valid_drop", 64'(ov[d]), 64'd0);
        chk("in_ready_after", 64'(irdy[d]), 64'd1);
        chk("result_hold", 64'(res[d]), 64'(v.res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        logic [10:0] hold_res;
        logic [63:0] hold_prod;
        logic        saw_valid;

        reset = 1'b1; a = '0; b = '0; sgn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0;
        end

        tbl.push_back('{32'h76543210, 32'h01234567, 1'b0, 11'd56,   64'h00060A0C0C0A0600});
        tbl.push_back('{32'hFFFFFFFF, 32'h77777777, 1'b1, 11'h7C8,  64'hF9F9F9F9F9F9F9F9});
        tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 11'h708,  64'hE1E1E1E1E1E1E1E1});
        tbl.push_back(model(32'h88888888, 32'h88888888, 1'b1));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(model($urandom, $urandom, 1'(i % 2)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(irdy[0]), 64'd0);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_result", 64'(res[0]), 64'd0);
        chk("rst_out_prod", prod[0], 64'd0);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("in_ready_post_rst", 64'(irdy[0]), 64'd1);

        for (int k = 0; k < tbl.size(); k++) begin
            run_txn(0, tbl[k], 2);
        end

        // Backpressure: in_valid pulsed in RUN and DONE, out_ready held low in DONE.
        v = tbl[0];
        @(negedge clk);
        a = v.a; b = v.b; sgn = v.sgn; iv[0] = 1'b1;
        @(posedge clk); #1;
        sb.push_back(v);
        a = tbl[2].a; b = tbl[2].b;
        chk("bp_in_ready_run", 64'(irdy[0]), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_out_valid", 64'(ov[0]), 64'd1);
        e = sb.pop_front();
        hold_res = res[0];
        hold_prod = prod[0];
        chk("bp_result", 64'(hold_res), 64'(e.res));
        chk("bp_prod", hold_prod, e.prod);
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1'(c % 2 == 0);
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(ov[0]), 64'd1);
            chk("bp_hold_result", 64'(res[0]), 64'(e.res));
            chk("bp_hold_prod", prod[0], e.prod);
            chk("bp_in_ready", 64'(irdy[0]), 64'd0);
        end
        iv[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_no_restart", 64'(irdy[0]), 64'd1);
        chk("bp_valid_low", 64'(ov[0]), 64'd0);
        iv[0] = 1'b0;

        // Reset after the first pass discards the transaction.
        @(negedge clk);
        a = tbl[2].a; b = tbl[2].b; sgn = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mr_in_ready", 64'(irdy[0]), 64'd0);
        chk("mr_out_valid", 64'(ov[0]), 64'd0);
        chk("mr_result", 64'(res[0]), 64'd0);
        chk("mr_prod", prod[0], 64'd0);
        chk("mr_busy", 64'(bsy[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            saw_valid = saw_valid | ov[0];
        end
        chk("mr_never_valid", 64'(saw_valid), 64'd0);
        run_txn(0, tbl[0], 2);

        // Lane-count variants.
        run_txn(1, tbl[0], 1);
        run_txn(2, tbl[0], 8);
        run_txn(1, tbl[1], 1);
        run_txn(2, tbl[4], 8);
        run_txn(1, tbl[5], 1);
        run_txn(2, tbl[6], 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
